// File: rtl/ssd1331_pkg.sv
`default_nettype none
// ============================================================================
// Module : ssd1331_pkg
// Brief  : SSD1331 opcode constants, parser state encoding and the opcode
//          argument-count lookup shared by the SPI receive monitor.
// Rev    : 1.0  initial release
// ============================================================================
package ssd1331_pkg;

  localparam logic [7:0] CMD_SET_COLUMN    = 8'h15;
  localparam logic [7:0] CMD_SET_ROW       = 8'h75;
  localparam logic [7:0] CMD_DRAW_LINE     = 8'h21;
  localparam logic [7:0] CMD_DRAW_RECT     = 8'h22;
  localparam logic [7:0] CMD_CLEAR_WINDOW  = 8'h25;
  localparam logic [7:0] CMD_FILL_ENABLE   = 8'h26;
  localparam logic [7:0] CMD_DISPLAY_OFF   = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON    = 8'hAF;

  typedef enum logic [0:0] {
    PS_IDLE = 1'b0,
    PS_ARGS = 1'b1
  } parser_state_e;

  // Returns {unknown, count}: number of argument bytes following an opcode.
  function automatic logic [4:0] ssd1331_argcount(input logic [7:0] opcode);
    logic [4:0] r;
    r = 5'b1_0000;
    case (opcode)
      CMD_SET_COLUMN, CMD_SET_ROW:                    r = 5'd2;
      8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C,
      8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1,
      8'hB3, 8'hBB, 8'hBE, CMD_FILL_ENABLE:           r = 5'd1;
      CMD_CLEAR_WINDOW:                               r = 5'd4;
      CMD_DRAW_LINE:                                  r = 5'd7;
      CMD_DRAW_RECT:                                  r = 5'd10;
      8'hA4, 8'hA5, 8'hA6, 8'hA7, CMD_DISPLAY_OFF,
      CMD_DISPLAY_ON, 8'h2E, 8'h2F, 8'hE3:            r = 5'd0;
      default:                                        r = 5'b1_0000;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssd1331_spi_rx_shift.sv
`default_nettype none
// ============================================================================
// Module : spi_rx_shift
// Brief  : Synchronises the raw SPI/DC/RES pins, detects SCK rising edges
//          while selected, deserialises MSB-first words and flags chip-select
//          releases that cut a word short. Outputs are single-cycle
//          combinational events; the parent registers them.
// Rev    : 1.0  initial release
// ============================================================================
module spi_rx_shift #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cs_i,
  input  logic             sck_i,
  input  logic             mosi_i,
  input  logic             dc_i,
  input  logic             res_i,
  output logic [WIDTH-1:0] byte_o,
  output logic             dc_o,
  output logic             fire_o,
  output logic             cs_err_o,
  output logic             res_n_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q, dc_sync_q, res_sync_q;
  logic                   cs_prev_q, sck_prev_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-2:0]       shift_q, shift_d;

  logic cs_s, sck_s, mosi_s, dc_s, res_s;
  logic cs_rise, sck_rise, last_bit;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];
  assign res_s  = res_sync_q[SYNC_STAGES-1];

  // A rising SCK that lands in the same sample as CS releasing still counts,
  // so a word finishing right at the end of a frame is not lost.
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign sck_rise = sck_s & ~sck_prev_q & (~cs_s | cs_rise);
  assign last_bit = (cnt_q == LAST_BIT);

  assign byte_o   = {shift_q, mosi_s};
  assign dc_o     = dc_s;
  assign fire_o   = res_s & sck_rise & last_bit;
  assign cs_err_o = res_s & cs_rise & (cnt_q != '0) & ~(sck_rise & last_bit);
  assign res_n_o  = res_s;

  // Bit counter and shift register next state; display reset or an aborted frame restart the word.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (!res_s) begin
      cnt_d = '0;
    end else begin
      if (sck_rise) begin
        shift_d = byte_o[WIDTH-2:0];
        cnt_d   = last_bit ? '0 : cnt_q + CW'(1);
      end
      if (cs_rise && !(sck_rise && last_bit)) begin
        cnt_d = '0;
      end
    end
  end

  // Input synchronisers, edge-history flops and deserialiser state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '1;
      res_sync_q  <= '1;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b1;
      cnt_q       <= '0;
      shift_q     <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      res_sync_q  <= {res_sync_q[SYNC_STAGES-2:0], res_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], dc_i};
      cs_prev_q   <= cs_s;
      sck_prev_q  <= sck_s;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ssd1331_spi_rx.sv
`default_nettype none
// ============================================================================
// Module : ssd1331_spi_rx
// Brief  : SSD1331 display-side SPI monitor. Receives bytes through
//          spi_rx_shift and frames command bytes into opcode + arguments,
//          tracking display on/off state.
//          Optional: SSD1331_RX_PIXEL_COUNT_EN adds o_PIXEL_CNT, counting
//          16-bit pixels written as DC=1 byte pairs.
// Rev    : 1.0  initial release
// ============================================================================
module ssd1331_spi_rx
  import ssd1331_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_CS,
  input  logic             i_SCK,
  input  logic             i_MOSI,
  input  logic             i_DC,
  input  logic             i_RES,
  output logic [WIDTH-1:0] o_BYTE,
  output logic             o_BYTE_DC,
  output logic             o_BYTE_VALID,
  output logic [7:0]       o_OPCODE,
  output logic [3:0]       o_ARG_IDX,
  output logic             o_ARG_VALID,
  output logic             o_CMD_DONE,
  output logic             o_CMD_UNKNOWN,
  output logic             o_DISPLAY_ON,
  output logic             o_FRAME_ERR
`ifdef SSD1331_RX_PIXEL_COUNT_EN
  ,
  output logic [15:0]      o_PIXEL_CNT
`endif
);

  logic [WIDTH-1:0] rx_byte;
  logic             rx_dc, rx_fire, rx_cs_err, rx_res_n;
  logic [7:0]       rx_op;
  logic [4:0]       argc;

  spi_rx_shift #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shift (
    .clk_i    (i_CLK),
    .rst_i    (i_RST),
    .cs_i     (i_CS),
    .sck_i    (i_SCK),
    .mosi_i   (i_MOSI),
    .dc_i     (i_DC),
    .res_i    (i_RES),
    .byte_o   (rx_byte),
    .dc_o     (rx_dc),
    .fire_o   (rx_fire),
    .cs_err_o (rx_cs_err),
    .res_n_o  (rx_res_n)
  );

  // The command parser only understands 8-bit words.
  assign rx_op = 8'(rx_byte);
  assign argc  = ssd1331_argcount(rx_op);

  parser_state_e    state_q, state_d;
  logic [3:0]       rem_q, rem_d, idx_q, idx_d;
  logic [WIDTH-1:0] byte_q, byte_d;
  logic             byte_dc_q, byte_dc_d, byte_valid_q, byte_valid_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [3:0]       arg_idx_q, arg_idx_d;
  logic             arg_valid_q, arg_valid_d, done_q, done_d, unk_q, unk_d;
  logic             disp_q, disp_d, ferr_q, ferr_d;

  assign o_BYTE        = byte_q;
  assign o_BYTE_DC     = byte_dc_q;
  assign o_BYTE_VALID  = byte_valid_q;
  assign o_OPCODE      = opcode_q;
  assign o_ARG_IDX     = arg_idx_q;
  assign o_ARG_VALID   = arg_valid_q;
  assign o_CMD_DONE    = done_q;
  assign o_CMD_UNKNOWN = unk_q;
  assign o_DISPLAY_ON  = disp_q;
  assign o_FRAME_ERR   = ferr_q;

  // Parser next state: all strobes are registered together so they coincide with o_BYTE_VALID.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    idx_d        = idx_q;
    byte_d       = byte_q;
    byte_dc_d    = byte_dc_q;
    byte_valid_d = 1'b0;
    opcode_d     = opcode_q;
    arg_idx_d    = arg_idx_q;
    arg_valid_d  = 1'b0;
    done_d       = 1'b0;
    unk_d        = 1'b0;
    disp_d       = disp_q;
    ferr_d       = 1'b0;
    if (!rx_res_n) begin
      state_d = PS_IDLE;
      rem_d   = 4'd0;
      idx_d   = 4'd0;
      disp_d  = 1'b0;
    end else begin
      if (rx_fire) begin
        byte_valid_d = 1'b1;
        byte_d       = rx_byte;
        byte_dc_d    = rx_dc;
        case (state_q)
          PS_IDLE: begin
            if (!rx_dc) begin
              opcode_d = rx_op;
              if (argc[3:0] == 4'd0) begin
                done_d = 1'b1;
                unk_d  = argc[4];
                if (rx_op == CMD_DISPLAY_ON)  disp_d = 1'b1;
                if (rx_op == CMD_DISPLAY_OFF) disp_d = 1'b0;
              end else begin
                rem_d   = argc[3:0];
                idx_d   = 4'd0;
                state_d = PS_ARGS;
              end
            end
          end
          PS_ARGS: begin
            if (!rx_dc) begin
              arg_valid_d = 1'b1;
              arg_idx_d   = idx_q;
              idx_d       = idx_q + 4'd1;
              rem_d       = rem_q - 4'd1;
              if (rem_q == 4'd1) begin
                done_d  = 1'b1;
                state_d = PS_IDLE;
              end
            end else begin
              // Pixel data while arguments are outstanding aborts the command.
              ferr_d  = 1'b1;
              state_d = PS_IDLE;
            end
          end
          default: state_d = PS_IDLE;
        endcase
      end
      if (rx_cs_err) ferr_d = 1'b1;
    end
  end

  // Parser and output registers.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q      <= PS_IDLE;
      rem_q        <= 4'd0;
      idx_q        <= 4'd0;
      byte_q       <= '0;
      byte_dc_q    <= 1'b0;
      byte_valid_q <= 1'b0;
      opcode_q     <= 8'd0;
      arg_idx_q    <= 4'd0;
      arg_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      unk_q        <= 1'b0;
      disp_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      idx_q        <= idx_d;
      byte_q       <= byte_d;
      byte_dc_q    <= byte_dc_d;
      byte_valid_q <= byte_valid_d;
      opcode_q     <= opcode_d;
      arg_idx_q    <= arg_idx_d;
      arg_valid_q  <= arg_valid_d;
      done_q       <= done_d;
      unk_q        <= unk_d;
      disp_q       <= disp_d;
      ferr_q       <= ferr_d;
    end
  end

`ifdef SSD1331_RX_PIXEL_COUNT_EN
  logic [15:0] pix_q, pix_d;
  logic        half_q, half_d;

  assign o_PIXEL_CNT = pix_q;

  // Pixel counter: two DC=1 bytes per pixel, restarted by a new column/row window.
  always_comb begin
    pix_d  = pix_q;
    half_d = half_q;
    if (!rx_res_n || (done_d && (opcode_d == CMD_SET_COLUMN || opcode_d == CMD_SET_ROW))) begin
      pix_d  = 16'd0;
      half_d = 1'b0;
    end else if (rx_fire && rx_dc) begin
      half_d = ~half_q;
      if (half_q) pix_d = pix_q + 16'd1;
    end
  end

  // Pixel counter registers.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      pix_q  <= 16'd0;
      half_q <= 1'b0;
    end else begin
      pix_q  <= pix_d;
      half_q <= half_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ssd1331_spi_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_ssd1331_spi_rx
// Brief  : Directed self-checking bench for ssd1331_spi_rx; serial stimulus
//          at SCK = i_CLK/4 with hand-computed expectations.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ssd1331_spi_rx;

  logic       i_CLK = 1'b0;
  logic       i_RST = 1'b1;
  logic       i_CS = 1'b1, i_SCK = 1'b1, i_MOSI = 1'b0, i_DC = 1'b0, i_RES = 1'b1;
  logic [7:0] o_BYTE;
  logic       o_BYTE_DC, o_BYTE_VALID;
  logic [7:0] o_OPCODE;
  logic [3:0] o_ARG_IDX;
  logic       o_ARG_VALID, o_CMD_DONE, o_CMD_UNKNOWN, o_DISPLAY_ON, o_FRAME_ERR;
`ifdef SSD1331_RX_PIXEL_COUNT_EN
  logic [15:0] o_PIXEL_CNT;
`endif

  ssd1331_spi_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_CS(i_CS), .i_SCK(i_SCK), .i_MOSI(i_MOSI),
    .i_DC(i_DC), .i_RES(i_RES), .o_BYTE(o_BYTE), .o_BYTE_DC(o_BYTE_DC),
    .o_BYTE_VALID(o_BYTE_VALID), .o_OPCODE(o_OPCODE), .o_ARG_IDX(o_ARG_IDX),
    .o_ARG_VALID(o_ARG_VALID), .o_CMD_DONE(o_CMD_DONE), .o_CMD_UNKNOWN(o_CMD_UNKNOWN),
    .o_DISPLAY_ON(o_DISPLAY_ON), .o_FRAME_ERR(o_FRAME_ERR)
`ifdef SSD1331_RX_PIXEL_COUNT_EN
    , .o_PIXEL_CNT(o_PIXEL_CNT)
`endif
  );

  always #5 i_CLK = ~i_CLK;

  int cyc = 0;
  always @(posedge i_CLK) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge.
  int         n_byte = 0, n_done = 0, n_ferr = 0, n_arg = 0, n_unk = 0, n_bad_done = 0;
  int         valid_cyc = 0;
  logic [7:0] last_byte = 8'h00;
  logic       last_dc = 1'b0;
  logic [7:0] done_op = 8'h00;
  logic       done_disp = 1'b0;
  logic [3:0] done_idx = 4'h0;
  logic [7:0] arg_byte_log [0:63];
  logic [3:0] arg_idx_log  [0:63];

  always @(negedge i_CLK) begin
    if (o_BYTE_VALID) begin
      n_byte    <= n_byte + 1;
      last_byte <= o_BYTE;
      last_dc   <= o_BYTE_DC;
      valid_cyc <= cyc;
    end
    if (o_ARG_VALID) begin
      arg_byte_log[n_arg[5:0]] <= o_BYTE;
      arg_idx_log[n_arg[5:0]]  <= o_ARG_IDX;
      n_arg <= n_arg + 1;
    end
    if (o_CMD_DONE) begin
      n_done    <= n_done + 1;
      done_op   <= o_OPCODE;
      done_disp <= o_DISPLAY_ON;
      done_idx  <= o_ARG_IDX;
      if (!o_BYTE_VALID) n_bad_done <= n_bad_done + 1;
      if (o_CMD_UNKNOWN) n_unk <= n_unk + 1;
    end
    if (o_FRAME_ERR) n_ferr <= n_ferr + 1;
  end

  int n_vec = 0, n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_CLK);
    #1;
  endtask

  int rise_cyc = 0;

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic dc);
    i_DC = dc;
    for (int i = 0; i < nbits; i++) begin
      i_SCK  = 1'b0;
      i_MOSI = b[7-i];
      tick(2);
      i_SCK  = 1'b1;
      rise_cyc = cyc;
      tick(2);
    end
  endtask

  task automatic cs_begin();
    i_CS = 1'b0;
    tick(2);
  endtask

  task automatic cs_end();
    tick(1);
    i_CS = 1'b1;
    tick(8);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic dc);
    cs_begin();
    send_bits(b, 8, dc);
    cs_end();
  endtask

  int b_byte, b_done, b_ferr, b_arg, b_unk;

  task automatic snap();
    b_byte = n_byte; b_done = n_done; b_ferr = n_ferr; b_arg = n_arg; b_unk = n_unk;
  endtask

  initial begin
    tick(5);
    i_RST = 1'b0;
    tick(3);

    // Reset state.
    check_eq("rst_valid", {31'd0, o_BYTE_VALID}, 32'd0);
    check_eq("rst_byte", {24'd0, o_BYTE}, 32'd0);
    check_eq("rst_disp", {31'd0, o_DISPLAY_ON}, 32'd0);
    check_eq("rst_opcode", {24'd0, o_OPCODE}, 32'd0);

    // Display on: zero-argument command completes with its own byte.
    snap();
    send_frame(8'hAF, 1'b0);
    check_eq("af_bytes", n_byte - b_byte, 1);
    check_eq("af_byte", {24'd0, last_byte}, 32'hAF);
    check_eq("af_done", n_done - b_done, 1);
    check_eq("af_disp_at_done", {31'd0, done_disp}, 32'd1);
    check_eq("af_latency", valid_cyc - rise_cyc, 3);

    // Display off.
    snap();
    send_frame(8'hAE, 1'b0);
    check_eq("ae_done", n_done - b_done, 1);
    check_eq("ae_disp", {31'd0, o_DISPLAY_ON}, 32'd0);

    // Set column: two arguments.
    snap();
    cs_begin();
    send_bits(8'h15, 8, 1'b0);
    send_bits(8'h00, 8, 1'b0);
    send_bits(8'h5F, 8, 1'b0);
    cs_end();
    check_eq("col_args", n_arg - b_arg, 2);
    check_eq("col_a0_idx", {28'd0, arg_idx_log[b_arg[5:0]]}, 0);
    check_eq("col_a0_byte", {24'd0, arg_byte_log[b_arg[5:0]]}, 32'h00);
    check_eq("col_a1_idx", {28'd0, arg_idx_log[6'(b_arg + 1)]}, 1);
    check_eq("col_a1_byte", {24'd0, arg_byte_log[6'(b_arg + 1)]}, 32'h5F);
    check_eq("col_done", n_done - b_done, 1);
    check_eq("col_opcode", {24'd0, done_op}, 32'h15);

    // Draw rectangle: 10 arguments across three frames.
    snap();
    cs_begin();
    send_bits(8'h22, 8, 1'b0);
    for (int k = 1; k <= 3; k++) send_bits(8'(k), 8, 1'b0);
    cs_end();
    cs_begin();
    for (int k = 4; k <= 7; k++) send_bits(8'(k), 8, 1'b0);
    cs_end();
    check_eq("rect_nodone_early", n_done - b_done, 0);
    cs_begin();
    for (int k = 8; k <= 10; k++) send_bits(8'(k), 8, 1'b0);
    cs_end();
    check_eq("rect_done", n_done - b_done, 1);
    check_eq("rect_idx", {28'd0, done_idx}, 9);
    check_eq("rect_opcode", {24'd0, done_op}, 32'h22);
    check_eq("rect_args", n_arg - b_arg, 10);

    // Chip select released after 5 bits, then a clean byte.
    snap();
    cs_begin();
    send_bits(8'hFF, 5, 1'b0);
    cs_end();
    check_eq("abort_ferr", n_ferr - b_ferr, 1);
    check_eq("abort_nobyte", n_byte - b_byte, 0);
    snap();
    send_frame(8'hA5, 1'b0);
    check_eq("a5_bytes", n_byte - b_byte, 1);
    check_eq("a5_byte", {24'd0, last_byte}, 32'hA5);
    check_eq("a5_noferr", n_ferr - b_ferr, 0);

    // Data byte while arguments pending.
    snap();
    cs_begin();
    send_bits(8'h15, 8, 1'b0);
    send_bits(8'h00, 8, 1'b0);
    send_bits(8'hF8, 8, 1'b1);
    cs_end();
    check_eq("dcerr_ferr", n_ferr - b_ferr, 1);
    check_eq("dcerr_nodone", n_done - b_done, 0);
    check_eq("dcerr_byte", {24'd0, last_byte}, 32'hF8);
    check_eq("dcerr_dc", {31'd0, last_dc}, 1);
    snap();
    send_frame(8'hAF, 1'b0);
    check_eq("dcerr_idle", n_done - b_done, 1);
    check_eq("dcerr_disp", {31'd0, o_DISPLAY_ON}, 32'd1);

    // Display reset mid-byte while arguments are pending.
    send_frame(8'h75, 1'b0);
    snap();
    cs_begin();
    send_bits(8'h3C, 3, 1'b0);
    i_RES = 1'b0;
    tick(6);
    check_eq("res_disp", {31'd0, o_DISPLAY_ON}, 32'd0);
    i_RES = 1'b1;
    tick(4);
    cs_end();
    check_eq("res_noferr", n_ferr - b_ferr, 0);
    check_eq("res_nobyte", n_byte - b_byte, 0);
    send_frame(8'hAF, 1'b0);
    check_eq("res_idle_done", n_done - b_done, 1);
    check_eq("res_idle_op", {24'd0, done_op}, 32'hAF);

    // Unknown opcode.
    snap();
    send_frame(8'h99, 1'b0);
    check_eq("unk_done", n_done - b_done, 1);
    check_eq("unk_flag", n_unk - b_unk, 1);
    check_eq("unk_op", {24'd0, o_OPCODE}, 32'h99);

`ifdef SSD1331_RX_PIXEL_COUNT_EN
    cs_begin();
    send_bits(8'h15, 8, 1'b0);
    send_bits(8'h00, 8, 1'b0);
    send_bits(8'h5F, 8, 1'b0);
    cs_end();
    check_eq("pix_clear", {16'd0, o_PIXEL_CNT}, 0);
    cs_begin();
    for (int k = 0; k < 6; k++) send_bits(8'hC3, 8, 1'b1);
    cs_end();
    check_eq("pix_cnt", {16'd0, o_PIXEL_CNT}, 3);
`endif

    check_eq("bad_done", n_bad_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
